// File: rtl/rw_ser_pkg.sv
// Shared types and constants for the rw byte serializer and its bit timer.
package rw_ser_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } ser_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

   function automatic int frame_bits(input int data_w, input bit parity);
      return data_w + 2 + (parity ? 1 : 0);
   endfunction

endpackage

// File: rtl/rw_bit_timer.sv
// Per-bit cycle counter; bit_done marks the last cycle of each serial bit.
module rw_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic bit_done
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;

   assign bit_done = !load && (cnt_q == LAST);

   always_ff @(posedge clk) begin
      if (!rst || load) begin
         cnt_q <= '0;
      end else if (bit_done) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/rw_byte_serializer.sv
// Byte-in, LSB-first framed serial-out transmitter with valid/ready handshake.
// Define RW_SER_PARITY_EN to insert an even-parity bit before the stop bit.
module rw_byte_serializer
   import rw_ser_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] __in0,
   input  logic              __in1,
   output logic              __out0,
   output logic              __out1,
   output logic              __out2
);

   localparam int IW = $clog2(DATA_W) + 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

   ser_state_t        state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic              bit_done;
   logic              line;
   logic              ready;
   logic              busy;
`ifdef RW_SER_PARITY_EN
   logic              par_q, par_d;
`endif

   rw_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (state_q == IDLE),
      .bit_done(bit_done)
   );

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      line    = LINE_IDLE;
      ready   = 1'b0;
      busy    = 1'b1;
`ifdef RW_SER_PARITY_EN
      par_d   = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            ready = 1'b1;
            busy  = 1'b0;
            if (__in1) begin
               state_d = START;
               shift_d = __in0;
               idx_d   = '0;
`ifdef RW_SER_PARITY_EN
               par_d   = ^__in0;
`endif
            end
         end
         START: begin
            line = START_BIT;
            if (bit_done) state_d = DATA;
         end
         DATA: begin
            line = shift_q[0];
            if (bit_done) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IW'(1);
               if (idx_q == LAST_IDX) begin
`ifdef RW_SER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef RW_SER_PARITY_EN
         PARITY: begin
            line = par_q;
            if (bit_done) state_d = STOP;
         end
`endif
         STOP: begin
            line = STOP_BIT;
            if (bit_done) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
`ifdef RW_SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
`ifdef RW_SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign __out0 = line;
   assign __out1 = ready;
   assign __out2 = busy;

endmodule
